mmio_console: RTL

Simulation-side memory-mapped console and halt device. It sits directly downstream of the core's data-memory bus inside the `simulation` top. Byte writes to the console address are captured into an output FIFO, which is drained over a valid/ready byte stream. A write to the halt address latches an exit code and signals end-of-run once the FIFO has drained.

---
 rtl/mmio_console_pkg.sv | 37 +++
 rtl/mmio_console_sync_fifo.sv | 65 ++++++
 rtl/mmio_console.sv | 110 +++++++++++
 3 files changed

// File: rtl/mmio_console_pkg.sv
// Shared widths, default addresses and the status-word layout for the MMIO console.
package mmio_console_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
    localparam logic [XLEN-1:0] HALT_ADDR_DEF    = 32'h1000_0004;

    localparam int ST_COUNT_W   = 16;
    localparam int ST_FULL_BIT  = 16;
    localparam int ST_HALT_BIT  = 17;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CONSOLE,
        SEL_HALT
    } req_sel_e;

    typedef struct packed {
        logic [XLEN-ST_HALT_BIT-2:0] rsvd;
        logic                        halted;
        logic                        full;
        logic [ST_COUNT_W-1:0]       count;
    } status_t;

    function automatic logic [XLEN-1:0] pack_status(input logic [ST_COUNT_W-1:0] count,
                                                    input logic full,
                                                    input logic halted);
        status_t s;
        s.rsvd   = '0;
        s.halted = halted;
        s.full   = full;
        s.count  = count;
        return s;
    endfunction

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through, registered full/empty/count.
// Latency: a push at edge N is visible at the head after edge N; pushes to a full FIFO and pops from an empty one are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_eff;
    logic             pop_eff;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign push_eff = push_vld_i && !full_o;
    assign pop_eff  = pop_i && !empty_o;

    // Pointers are exactly AW bits so they wrap on their own at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console byte sink plus halt/exit-code latch for simulation tops.
// Latency: bus ack is combinational; queued bytes appear on tx one cycle after acceptance. Full FIFO stalls console stores.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [XLEN-1:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [XLEN-1:0] HALT_ADDR    = HALT_ADDR_DEF,
    parameter int              FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bus_valid,
    input  logic            bus_write,
    input  logic [XLEN-1:0] bus_addr,
    input  logic [XLEN-1:0] bus_wdata,
    output logic            bus_ready,
    output logic [XLEN-1:0] bus_rdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            halted,
    output logic [XLEN-1:0] exit_code,
    output logic            done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    req_sel_e        sel;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            push;
    logic            halt_accept;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] exit_code_q, exit_code_d;

    always_comb begin
        sel = SEL_NONE;
        if (bus_valid) begin
            if (bus_addr == CONSOLE_ADDR)   sel = SEL_CONSOLE;
            else if (bus_addr == HALT_ADDR) sel = SEL_HALT;
        end
    end

    // Stores stall on the registered full flag, so a pop in the same cycle
    // only frees the slot for the next cycle.
    always_comb begin
        bus_ready   = 1'b0;
        bus_rdata   = '0;
        push        = 1'b0;
        halt_accept = 1'b0;
        case (sel)
            SEL_CONSOLE: begin
                if (bus_write) begin
                    bus_ready = !fifo_full;
                    push      = !fifo_full;
                end else begin
                    bus_ready = 1'b1;
                    bus_rdata = pack_status(ST_COUNT_W'(fifo_count), fifo_full, halted_q);
                end
            end
            SEL_HALT: begin
                bus_ready = 1'b1;
                if (bus_write) halt_accept = 1'b1;
                else           bus_rdata   = exit_code_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        halted_d    = halted_q;
        exit_code_d = exit_code_q;
        if (halt_accept && !halted_q) begin
            halted_d    = 1'b1;
            exit_code_d = bus_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_q    <= 1'b0;
            exit_code_q <= '0;
        end else begin
            halted_q    <= halted_d;
            exit_code_q <= exit_code_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_vld_i (push),
        .push_dat_i (bus_wdata[7:0]),
        .pop_i      (tx_valid && tx_ready),
        .head_dat_o (tx_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign tx_valid  = !fifo_empty;
    assign halted    = halted_q;
    assign exit_code = exit_code_q;
    assign done      = halted_q && fifo_empty;

endmodule
